uart_rx_checker: RTL and testbench
==================================

Name: uart_rx_checker

Overview:
Receive-side consumer for the UART receiver; the counterpart of the transmitter driver.
- Watches Rx_VALID / Rx_FERROR / Rx_PERROR / Rx_DATA and checks the byte stream against the fixed 4-byte message the transmitter driver sends.
- Counts good messages and errors, latches the last complete message for display, and flags any error in a sticky flag.
- Sits in the uart top level beside uart_receiver, fed directly by its outputs.

Parameters:
BYTE0, 8'hAA, expected message byte 0 (also the resync byte)
BYTE1, 8'h55, expected message byte 1
BYTE2, 8'hCC, expected message byte 2
BYTE3, 8'h89, expected message byte 3
TIMEOUT, 2000000, max clk cycles between bytes inside a message before the partial message is aborted
TW, $clog2(TIMEOUT), timeout counter width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear of counters, flag, last_msg and FSM
Rx_DATA  in  8  received byte from uart_receiver
Rx_VALID  in  1  byte valid (may be held >1 cycle)
Rx_FERROR  in  1  framing error from uart_receiver
Rx_PERROR  in  1  parity error from uart_receiver
msg_ok  out  1  one-cycle pulse per correctly received 4-byte message
msg_count  out  8  good messages, saturates at 255
err_count  out  8  error events, saturates at 255
byte_index  out  2  next expected byte position (0..3)
last_msg  out  32  last good message, {byte0,byte1,byte2,byte3}
error_flag  out  1  sticky; set by any error event

Behaviour:
- Reset (reset==0, asynchronous): FSM=IDLE; input/edge registers cleared; all outputs 0.
- Input stage: Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_DATA registered at every edge into a sample stage. A previous-sample register holds the prior value of any=(VALID|FERROR|PERROR).
- Event: sampled any==1 and previous==0. Exactly one event per assertion, however long it is held.
- Event timing: if the inputs are first sampled high at edge k, the event acts at edge k+1.
- Error byte: event with sampled FERROR|PERROR. In any state: err_count+1 (saturating), error_flag=1, FSM->IDLE, byte_index=0.
- FSM states:
  - IDLE (byte_index=0): good byte ==BYTE0 -> COLLECT, byte_index=1, timeout counter=0. Any other good byte -> error event, stay IDLE.
  - COLLECT (byte_index 1..3):
    - Good byte == expected[byte_index] with byte_index<3: byte stored, byte_index+1, timeout counter=0.
    - Good byte == BYTE3 at index 3: -> REPORT. At the same edge: last_msg={stored0..2,byte}, msg_count+1 (saturating), msg_ok=1.
    - Good byte mismatch: error event. If byte==BYTE0 -> byte_index=1, stay COLLECT, counter=0; else -> IDLE, byte_index=0.
    - No event: timeout counter+1. When it reaches TIMEOUT-1: error event, -> IDLE, byte_index=0.
  - REPORT: lasts one cycle, msg_ok=1 only here, byte_index=0. Next edge -> IDLE. An event in this cycle is processed with IDLE rules, so BYTE0 -> COLLECT index 1.
- msg_ok is registered: high exactly in the cycle after the edge that takes the FSM into REPORT.
- Error event effects: err_count+1 (saturating at 8'hFF, no wrap) and error_flag=1.
- clear==1 at an edge: same effect as reset, but synchronous. Priority: reset > clear > event > timeout.
- Counter widths: counters hold at 255. The timeout counter never exceeds TIMEOUT-1.
- Reset mid-message: partial bytes discarded; last_msg returns to 0.

Decomposition:
- Shared include uart_defs.vh:
  - default message bytes (shared with uart_transmitter_driver so both ends agree)
  - FSM state encodings IDLE=2'd0, COLLECT=2'd1, REPORT=2'd2
- One sub-module, uart_rx_event_detect: input register stage plus rising-edge detect. Outputs ev_good, ev_err, data_q.

Test Plan:
1. Reset low then high; feed AA,55,CC,89 as single-cycle Rx_VALID pulses 100 cycles apart -> one msg_ok pulse, msg_count=1, last_msg=32'hAA55CC89, err_count=0, error_flag=0.
2. Hold Rx_VALID high 20 cycles per byte for AA,55,CC,89 twice -> msg_count=2, exactly two msg_ok pulses.
3. Feed AA,55 then a byte with Rx_PERROR=1 -> err_count=1, error_flag=1, byte_index=0. Then a full message -> msg_count=1.
4. Feed AA,55,AA,55,CC,89 -> err_count=1 (third byte mismatch, resync to index 1); then msg_count=1 and last_msg=32'hAA55CC89.
5. With TIMEOUT=50, feed AA then wait 60 cycles -> at cycle 49 after the event: err_count=1, byte_index=0. A following 55 counts as an error (err_count=2).
6. Inject 300 error bytes -> err_count stays 255. Pulse clear -> all counters 0, error_flag=0. Assert reset mid-message (after AA,55) -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/uart_rx_checker_pkg.sv
// Shared definitions for the UART receive-side checker: message bytes,
// FSM state encoding and a saturating counter helper.
package uart_rx_checker_pkg;

    localparam logic [7:0] MSG_BYTE0 = 8'hAA;
    localparam logic [7:0] MSG_BYTE1 = 8'h55;
    localparam logic [7:0] MSG_BYTE2 = 8'hCC;
    localparam logic [7:0] MSG_BYTE3 = 8'h89;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } rx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/uart_rx_event_detect.sv
// Registers the receiver handshake and produces one event per rising edge
// of (valid|ferror|perror), split into good-byte and error-byte events.
module uart_rx_event_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       valid_i,
    input  logic       ferr_i,
    input  logic       perr_i,
    input  logic [7:0] data_i,
    output logic       ev_good_o,
    output logic       ev_err_o,
    output logic [7:0] data_o
);

    logic       valid_q;
    logic       ferr_q;
    logic       perr_q;
    logic [7:0] data_q;
    logic       prev_any_q;
    logic       any_s;
    logic       event_s;

    assign any_s   = valid_q | ferr_q | perr_q;
    assign event_s = any_s & ~prev_any_q;

    // Sample stage plus the previous-sample register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= 8'h00;
            prev_any_q <= 1'b0;
        end else if (clear_i) begin
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= 8'h00;
            prev_any_q <= 1'b0;
        end else begin
            valid_q    <= valid_i;
            ferr_q     <= ferr_i;
            perr_q     <= perr_i;
            data_q     <= data_i;
            prev_any_q <= any_s;
        end
    end

    assign ev_err_o  = event_s & (ferr_q | perr_q);
    assign ev_good_o = event_s & ~(ferr_q | perr_q);
    assign data_o    = data_q;

endmodule

// File: rtl/uart_rx_checker.sv
// Checks the received byte stream against the fixed 4-byte message,
// counting good messages and errors and latching the last good message.
module uart_rx_checker
    import uart_rx_checker_pkg::*;
#(
    parameter logic [7:0] BYTE0   = MSG_BYTE0,
    parameter logic [7:0] BYTE1   = MSG_BYTE1,
    parameter logic [7:0] BYTE2   = MSG_BYTE2,
    parameter logic [7:0] BYTE3   = MSG_BYTE3,
    parameter int         TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  Rx_DATA,
    input  logic        Rx_VALID,
    input  logic        Rx_FERROR,
    input  logic        Rx_PERROR,
    output logic        msg_ok,
    output logic [7:0]  msg_count,
    output logic [7:0]  err_count,
    output logic [1:0]  byte_index,
    output logic [31:0] last_msg,
    output logic        error_flag
);

    localparam int            TW       = $clog2(TIMEOUT);
    // Fires on the edge at which the idle count would reach TIMEOUT-1.
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 2);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);

    logic       ev_good_s;
    logic       ev_err_s;
    logic [7:0] data_s;

    rx_state_e     state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [31:0]   last_q, last_d;
    logic [7:0]    msg_cnt_q, msg_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          flag_q, flag_d;
    logic          msg_ok_q, msg_ok_d;
    logic          err_ev_s;
    logic [7:0]    exp_s;

    uart_rx_event_detect u_detect (
        .clk       (clk),
        .rst_n     (reset),
        .clear_i   (clear),
        .valid_i   (Rx_VALID),
        .ferr_i    (Rx_FERROR),
        .perr_i    (Rx_PERROR),
        .data_i    (Rx_DATA),
        .ev_good_o (ev_good_s),
        .ev_err_o  (ev_err_s),
        .data_o    (data_s)
    );

    // Expected byte for the current collect position.
    always_comb begin
        exp_s = BYTE0;
        case (idx_q)
            2'd1:    exp_s = BYTE1;
            2'd2:    exp_s = BYTE2;
            2'd3:    exp_s = BYTE3;
            default: exp_s = BYTE0;
        endcase
    end

    // Next-state, datapath and counter update.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        last_d    = last_q;
        msg_cnt_d = msg_cnt_q;
        err_cnt_d = err_cnt_q;
        flag_d    = flag_q;
        msg_ok_d  = 1'b0;
        err_ev_s  = 1'b0;

        if (ev_err_s) begin
            err_ev_s = 1'b1;
            state_d  = ST_IDLE;
            idx_d    = 2'd0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_REPORT: begin
                    cnt_d = '0;
                    if (ev_good_s && (data_s == BYTE0)) begin
                        state_d = ST_COLLECT;
                        idx_d   = 2'd1;
                        b0_d    = data_s;
                    end else if (ev_good_s) begin
                        err_ev_s = 1'b1;
                        state_d  = ST_IDLE;
                        idx_d    = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                    end
                end
                ST_COLLECT: begin
                    if (ev_good_s && (data_s == exp_s) && (idx_q == 2'd3)) begin
                        state_d   = ST_REPORT;
                        idx_d     = 2'd0;
                        cnt_d     = '0;
                        last_d    = {b0_q, b1_q, b2_q, data_s};
                        msg_cnt_d = sat_inc8(msg_cnt_q);
                        msg_ok_d  = 1'b1;
                    end else if (ev_good_s && (data_s == exp_s)) begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = '0;
                        if (idx_q == 2'd1) begin
                            b1_d = data_s;
                        end else begin
                            b2_d = data_s;
                        end
                    end else if (ev_good_s && (data_s == BYTE0)) begin
                        err_ev_s = 1'b1;
                        idx_d    = 2'd1;
                        cnt_d    = '0;
                        b0_d     = data_s;
                    end else if (ev_good_s || (cnt_q == CNT_LAST)) begin
                        err_ev_s = 1'b1;
                        state_d  = ST_IDLE;
                        idx_d    = 2'd0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        if (err_ev_s) begin
            err_cnt_d = sat_inc8(err_cnt_q);
            flag_d    = 1'b1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers; clear behaves like a synchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            b0_q      <= 8'h00;
            b1_q      <= 8'h00;
            b2_q      <= 8'h00;
            last_q    <= 32'h0000_0000;
            msg_cnt_q <= 8'h00;
            err_cnt_q <= 8'h00;
            flag_q    <= 1'b0;
            msg_ok_q  <= 1'b0;
        end else if (clear) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            b0_q      <= 8'h00;
            b1_q      <= 8'h00;
            b2_q      <= 8'h00;
            last_q    <= 32'h0000_0000;
            msg_cnt_q <= 8'h00;
            err_cnt_q <= 8'h00;
            flag_q    <= 1'b0;
            msg_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            last_q    <= last_d;
            msg_cnt_q <= msg_cnt_d;
            err_cnt_q <= err_cnt_d;
            flag_q    <= flag_d;
            msg_ok_q  <= msg_ok_d;
        end
    end

    assign msg_ok     = msg_ok_q;
    assign msg_count  = msg_cnt_q;
    assign err_count  = err_cnt_q;
    assign byte_index = idx_q;
    assign last_msg   = last_q;
    assign error_flag = flag_q;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Self-checking bench for uart_rx_checker: directed scenarios plus a random
// byte stream compared against a message-matching reference model.
module tb_uart_rx_checker;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  Rx_DATA = 8'h00;
    logic        Rx_VALID = 1'b0;
    logic        Rx_FERROR = 1'b0;
    logic        Rx_PERROR = 1'b0;
    logic        msg_ok;
    logic [7:0]  msg_count;
    logic [7:0]  err_count;
    logic [1:0]  byte_index;
    logic [31:0] last_msg;
    logic        error_flag;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] exp_msg [4] = '{8'hAA, 8'h55, 8'hCC, 8'h89};
    int          m_pos = 0;
    int          m_msgs = 0;
    int          m_errs = 0;
    logic        m_flag = 1'b0;
    logic [31:0] m_last = 32'h0;
    int          m_pulses = 0;
    int          mon_pulses = 0;

    uart_rx_checker #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_FERROR  (Rx_FERROR),
        .Rx_PERROR  (Rx_PERROR),
        .msg_ok     (msg_ok),
        .msg_count  (msg_count),
        .err_count  (err_count),
        .byte_index (byte_index),
        .last_msg   (last_msg),
        .error_flag (error_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (msg_ok === 1'b1) mon_pulses++;
    end

    task automatic model_err();
        m_errs = (m_errs >= 255) ? 255 : m_errs + 1;
        m_flag = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] d, input logic bad);
        if (bad) begin
            model_err();
            m_pos = 0;
        end else if (d == exp_msg[m_pos]) begin
            if (m_pos == 3) begin
                m_msgs   = (m_msgs >= 255) ? 255 : m_msgs + 1;
                m_last   = {exp_msg[0], exp_msg[1], exp_msg[2], d};
                m_pulses = m_pulses + 1;
                m_pos    = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            model_err();
            m_pos = (d == exp_msg[0]) ? 1 : 0;
        end
    endtask

    task automatic model_zero();
        m_pos = 0; m_msgs = 0; m_errs = 0; m_flag = 1'b0; m_last = 32'h0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe,
                             input int hold, input int gap);
        @(negedge clk);
        Rx_DATA = d; Rx_VALID = 1'b1; Rx_FERROR = fe; Rx_PERROR = pe;
        repeat (hold) @(negedge clk);
        Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
        repeat (gap) @(negedge clk);
        model_byte(d, fe | pe);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_zero();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (msg_count !== 8'd0 || err_count !== 8'd0) begin nerr++; $display("FAIL reset_counts: msg=%0d err=%0d, required 0 0", msg_count, err_count); end
        nvec++; if (last_msg !== 32'h0 || byte_index !== 2'd0 || error_flag !== 1'b0 || msg_ok !== 1'b0) begin nerr++; $display("FAIL reset_outs: last=%h idx=%0d flag=%b ok=%b, required all 0", last_msg, byte_index, error_flag, msg_ok); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_message();
        int p0;
        p0 = mon_pulses;
        for (int i = 0; i < 4; i++) send_byte(exp_msg[i], 1'b0, 1'b0, 1, 30);
        nvec++; if (msg_count !== 8'(m_msgs) || msg_count !== 8'd1) begin nerr++; $display("FAIL single_msg_count: got %0d, required 1", msg_count); end
        nvec++; if (last_msg !== 32'hAA55CC89) begin nerr++; $display("FAIL single_last_msg: got %h, required aa55cc89", last_msg); end
        nvec++; if (err_count !== 8'd0 || error_flag !== 1'b0) begin nerr++; $display("FAIL single_no_err: err=%0d flag=%b, required 0 0", err_count, error_flag); end
        nvec++; if (mon_pulses - p0 != 1) begin nerr++; $display("FAIL single_pulses: got %0d msg_ok cycles, required 1", mon_pulses - p0); end
    endtask

    task automatic test_held_valid();
        int p0;
        do_clear();
        p0 = mon_pulses;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) send_byte(exp_msg[i], 1'b0, 1'b0, 20, 5);
        nvec++; if (msg_count !== 8'd2) begin nerr++; $display("FAIL held_msg_count: got %0d, required 2", msg_count); end
        nvec++; if (mon_pulses - p0 != 2) begin nerr++; $display("FAIL held_pulses: got %0d, required 2", mon_pulses - p0); end
        nvec++; if (err_count !== 8'd0) begin nerr++; $display("FAIL held_err: got %0d, required 0", err_count); end
    endtask

    task automatic test_parity_error();
        do_clear();
        send_byte(8'hAA, 1'b0, 1'b0, 1, 5);
        send_byte(8'h55, 1'b0, 1'b0, 1, 5);
        send_byte(8'hCC, 1'b0, 1'b1, 1, 5);
        nvec++; if (err_count !== 8'd1 || error_flag !== 1'b1 || byte_index !== 2'd0) begin nerr++; $display("FAIL perr_effect: err=%0d flag=%b idx=%0d, required 1 1 0", err_count, error_flag, byte_index); end
        for (int i = 0; i < 4; i++) send_byte(exp_msg[i], 1'b0, 1'b0, 1, 5);
        nvec++; if (msg_count !== 8'd1 || err_count !== 8'd1) begin nerr++; $display("FAIL perr_recover: msg=%0d err=%0d, required 1 1", msg_count, err_count); end
    endtask

    task automatic test_resync();
        logic [7:0] seq [6] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hCC, 8'h89};
        do_clear();
        for (int i = 0; i < 3; i++) send_byte(seq[i], 1'b0, 1'b0, 1, 4);
        nvec++; if (err_count !== 8'd1 || byte_index !== 2'd1) begin nerr++; $display("FAIL resync_point: err=%0d idx=%0d, required 1 1", err_count, byte_index); end
        for (int i = 3; i < 6; i++) send_byte(seq[i], 1'b0, 1'b0, 1, 4);
        nvec++; if (msg_count !== 8'd1 || last_msg !== 32'hAA55CC89 || err_count !== 8'd1) begin nerr++; $display("FAIL resync_msg: msg=%0d last=%h err=%0d, required 1 aa55cc89 1", msg_count, last_msg, err_count); end
    endtask

    task automatic test_timeout();
        do_clear();
        @(negedge clk);
        Rx_DATA = 8'hAA; Rx_VALID = 1'b1;
        @(negedge clk);
        Rx_VALID = 1'b0;
        @(negedge clk);
        repeat (TO - 2) @(negedge clk);
        nvec++; if (err_count !== 8'd0 || byte_index !== 2'd1) begin nerr++; $display("FAIL timeout_early: err=%0d idx=%0d, required 0 1", err_count, byte_index); end
        @(negedge clk);
        nvec++; if (err_count !== 8'd1 || byte_index !== 2'd0 || error_flag !== 1'b1) begin nerr++; $display("FAIL timeout_fire: err=%0d idx=%0d flag=%b, required 1 0 1", err_count, byte_index, error_flag); end
        repeat (10) @(negedge clk);
        m_errs = 1; m_flag = 1'b1; m_pos = 0;
        send_byte(8'h55, 1'b0, 1'b0, 1, 4);
        nvec++; if (err_count !== 8'd2) begin nerr++; $display("FAIL timeout_after: err=%0d, required 2", err_count); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       bad;
        int         r;
        do_clear();
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) d = exp_msg[m_pos];
            else if (r < 7) d = 8'hAA;
            else d = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            send_byte(d, bad & $urandom_range(0, 1) == 1, bad, $urandom_range(1, 4), $urandom_range(2, 12));
            nvec++; if (msg_count !== 8'(m_msgs) || err_count !== 8'(m_errs) || byte_index !== 2'(m_pos)) begin nerr++; $display("FAIL rand_state[%0d]: msg=%0d err=%0d idx=%0d, required %0d %0d %0d", n, msg_count, err_count, byte_index, m_msgs, m_errs, m_pos); end
            nvec++; if (error_flag !== m_flag || last_msg !== m_last) begin nerr++; $display("FAIL rand_flag_last[%0d]: flag=%b last=%h, required %b %h", n, error_flag, last_msg, m_flag, m_last); end
        end
        nvec++; if (mon_pulses !== m_pulses) begin nerr++; $display("FAIL rand_pulses: got %0d, required %0d", mon_pulses, m_pulses); end
    endtask

    task automatic test_saturate_clear_reset();
        do_clear();
        for (int n = 0; n < 300; n++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1, 2);
        nvec++; if (err_count !== 8'd255 || error_flag !== 1'b1) begin nerr++; $display("FAIL err_saturate: err=%0d flag=%b, required 255 1", err_count, error_flag); end
        do_clear();
        @(negedge clk);
        nvec++; if (err_count !== 8'd0 || msg_count !== 8'd0 || error_flag !== 1'b0 || byte_index !== 2'd0 || last_msg !== 32'h0) begin nerr++; $display("FAIL clear_all: err=%0d msg=%0d flag=%b idx=%0d last=%h, required all 0", err_count, msg_count, error_flag, byte_index, last_msg); end
        for (int i = 0; i < 4; i++) send_byte(exp_msg[i], 1'b0, 1'b0, 1, 4);
        send_byte(8'hAA, 1'b0, 1'b0, 1, 4);
        send_byte(8'h55, 1'b0, 1'b0, 1, 4);
        nvec++; if (msg_count !== 8'd1 || byte_index !== 2'd2) begin nerr++; $display("FAIL pre_reset: msg=%0d idx=%0d, required 1 2", msg_count, byte_index); end
        #2;
        reset = 1'b0;
        #1;
        nvec++; if (msg_count !== 8'd0 || err_count !== 8'd0 || byte_index !== 2'd0 || last_msg !== 32'h0 || error_flag !== 1'b0 || msg_ok !== 1'b0) begin nerr++; $display("FAIL async_reset: msg=%0d err=%0d idx=%0d last=%h flag=%b ok=%b, required all 0", msg_count, err_count, byte_index, last_msg, error_flag, msg_ok); end
        model_zero();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_message();
        test_held_valid();
        test_parity_error();
        test_resync();
        test_timeout();
        test_random();
        test_saturate_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
